// File: rtl/keccak_squeezer.sv
// Squeeze engine: streams the rate lanes of a permuted Keccak state as 64-bit words.
// Define SQUEEZE_XOF_EN to allow multi-block (extendable-output) squeezing via perm_req.
module keccak_squeezer #(
    parameter int RATE_WORDS = 9,
    parameter int LEN_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [1599:0]    state_in,
    input  logic             state_valid,
    output logic             perm_req,
    output logic [63:0]      out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W = (RATE_WORDS > 1) ? $clog2(RATE_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATE_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        EMIT = 2'd2
`ifdef SQUEEZE_XOF_EN
        , REQ = 2'd3
`endif
    } state_t;

    state_t             state, next_state;
    logic [63:0]        buffer [RATE_WORDS];
    logic [IDX_W-1:0]   idx;
    logic [LEN_W-1:0]   rem;
    logic [LEN_W-1:0]   load_len;
    logic               handshake;
    logic               unused_state_bits;

    // Capacity lanes never leave the core; they are only referenced to keep them visible as intentionally unused.
    assign unused_state_bits = ^state_in;

`ifdef SQUEEZE_XOF_EN
    assign load_len = len;
`else
    assign load_len = (len > LEN_W'(RATE_WORDS)) ? LEN_W'(RATE_WORDS) : len;
`endif

    assign handshake = out_valid && out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        out        = 64'd0;
        perm_req   = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (start && (len != '0)) begin
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (state_valid) begin
                    next_state = EMIT;
                end
            end
            EMIT: begin
                out_valid = 1'b1;
                out_last  = (rem == LEN_W'(1));
                out       = buffer[idx];
                if (out_valid && out_ready) begin
                    if (rem == LEN_W'(1)) begin
                        next_state = IDLE;
`ifdef SQUEEZE_XOF_EN
                    end else if (idx == LAST_IDX) begin
                        next_state = REQ;
`endif
                    end
                end
            end
`ifdef SQUEEZE_XOF_EN
            REQ: begin
                perm_req   = 1'b1;
                next_state = WAIT;
            end
`endif
            default: next_state = IDLE;
        endcase
    end

    // Datapath: rate buffer, lane index, remaining count and the done pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < RATE_WORDS; k++) begin
                buffer[k] <= 64'd0;
            end
            idx  <= '0;
            rem  <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && (len != '0)) begin
                        rem <= load_len;
                    end
                end
                WAIT: begin
                    if (state_valid) begin
                        for (int k = 0; k < RATE_WORDS; k++) begin
                            buffer[k] <= state_in[1599 - 64*k -: 64];
                        end
                        idx <= '0;
                    end
                end
                EMIT: begin
                    if (handshake) begin
                        rem <= rem - LEN_W'(1);
                        if (rem == LEN_W'(1)) begin
                            done <= 1'b1;
                        end else if (idx != LAST_IDX) begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_keccak_squeezer.sv
// Scoreboard bench for keccak_squeezer: expected lanes are queued when a request is
// issued and compared as the squeezer hands them out.
module tb_keccak_squeezer;

    localparam int RATE_WORDS = 9;
    localparam int LEN_W      = 16;
`ifdef SQUEEZE_XOF_EN
    localparam bit XOF = 1'b1;
`else
    localparam bit XOF = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [LEN_W-1:0] len;
    logic [1599:0]    state_in;
    logic             state_valid;
    logic             perm_req;
    logic [63:0]      out;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic             busy;
    logic             done;

    typedef struct {
        logic [63:0] lane;
        logic        last;
    } exp_t;

    exp_t sb[$];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int permCount   = 0;
    int doneCount   = 0;
    int firstCyc    = 0;
    int lastHsCyc   = 0;
    bit tracking    = 1'b0;

    keccak_squeezer #(.RATE_WORDS(RATE_WORDS), .LEN_W(LEN_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .len         (len),
        .state_in    (state_in),
        .state_valid (state_valid),
        .perm_req    (perm_req),
        .out         (out),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [63:0] laneValue(input int seed, input int blk, input int k);
        return (64'(seed) << 32) | (64'(blk) << 16) | 64'(k);
    endfunction

    function automatic logic [1599:0] makeState(input int seed, input int blk);
        logic [1599:0] s;
        s = '0;
        for (int k = 0; k < 25; k++) begin
            s[1599 - 64*k -: 64] = laneValue(seed, blk, k);
        end
        return s;
    endfunction

    // Lane monitor: every valid cycle is compared against the head of the scoreboard.
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            if (perm_req) permCount++;
            if (done) begin
                doneCount++;
                checkOutput("done_gap", 64'(cyc - lastHsCyc), 64'd1);
                checkOutput("busy_at_done", 64'(busy), 64'd0);
            end
            if (out_valid) begin
                if (!tracking) begin
                    tracking = 1'b1;
                    firstCyc = cyc;
                end
                if (sb.size() == 0) begin
                    checkOutput("extra_lane", 64'd1, 64'd0);
                end else begin
                    checkOutput("lane", out, sb[0].lane);
                    checkOutput("last", 64'(out_last), 64'(sb[0].last));
                    if (out_ready) begin
                        if (sb[0].last) lastHsCyc = cyc;
                        void'(sb.pop_front());
                    end
                end
            end
        end
    end

    // Issues one request starting in the current cycle and serves perm_req with fresh states.
    task automatic applyStimulus(input int reqLen, input int seed, input bit toggle, input bit poke);
        int n;
        int blk;
        int permStart;
        int doneStart;
        bit pending;
        bit doneSeen;
        n = (!XOF && reqLen > RATE_WORDS) ? RATE_WORDS : reqLen;
        for (int i = 0; i < n; i++) begin
            sb.push_back('{laneValue(seed, i / RATE_WORDS, i % RATE_WORDS), (i == n - 1)});
        end
        permStart = permCount;
        doneStart = doneCount;
        tracking  = 1'b0;
        start = 1'b1;
        len   = LEN_W'(reqLen);
        @(posedge clk); #1;
        start       = 1'b0;
        state_valid = 1'b1;
        state_in    = makeState(seed, 0);
        out_ready   = 1'b0;
        checkOutput("wait_no_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        state_valid = 1'b0;
        out_ready   = 1'b1;
        checkOutput("latency", 64'(out_valid), 64'd1);
        blk      = 1;
        pending  = 1'b0;
        doneSeen = 1'b0;
        for (int it = 0; it < 300 && !doneSeen; it++) begin
            @(negedge clk);
            if (perm_req) pending = 1'b1;
            if (done) doneSeen = 1'b1;
            @(posedge clk); #1;
            out_ready   = toggle ? ~out_ready : 1'b1;
            start       = 1'b0;
            state_valid = 1'b0;
            if (pending) begin
                state_valid = 1'b1;
                state_in    = makeState(seed, blk);
                blk++;
                pending = 1'b0;
            end else if (poke && it == 1) begin
                start       = 1'b1;
                len         = LEN_W'(3);
                state_valid = 1'b1;
                state_in    = makeState(99, 9);
            end
        end
        start       = 1'b0;
        state_valid = 1'b0;
        out_ready   = 1'b1;
        if (!doneSeen) checkOutput("timeout", 64'd0, 64'd1);
        checkOutput("sb_empty", 64'(sb.size()), 64'd0);
        checkOutput("perm_count", 64'(permCount - permStart), XOF ? 64'((n - 1) / RATE_WORDS) : 64'd0);
        checkOutput("done_count", 64'(doneCount - doneStart), 64'd1);
    endtask

    initial begin
        reset       = 1'b0;
        start       = 1'b0;
        len         = '0;
        state_in    = '0;
        state_valid = 1'b0;
        out_ready   = 1'b1;
        #12;
        checkOutput("rst_out", out, 64'd0);
        checkOutput("rst_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_perm", 64'(perm_req), 64'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        $display("[TB] short request, back-to-back, toggled ready");
        applyStimulus(4, 0, 1'b0, 1'b0);
        applyStimulus(9, 1, 1'b1, 1'b0);
        checkOutput("stall_span", 64'(lastHsCyc - firstCyc + 1), 64'd17);

        $display("[TB] long request (XOF=%0d)", XOF);
        applyStimulus(20, 2, 1'b0, 1'b0);

        $display("[TB] start and state_valid while emitting");
        applyStimulus(4, 3, 1'b0, 1'b1);

        $display("[TB] zero-length start");
        begin
            int doneStart;
            doneStart = doneCount;
            start = 1'b1;
            len   = '0;
            @(posedge clk); #1;
            start = 1'b0;
            checkOutput("len0_busy", 64'(busy), 64'd0);
            state_valid = 1'b1;
            state_in    = makeState(4, 0);
            @(posedge clk); #1;
            state_valid = 1'b0;
            repeat (3) begin
                @(posedge clk); #1;
            end
            checkOutput("len0_idle", 64'(busy), 64'd0);
            checkOutput("len0_nodone", 64'(doneCount - doneStart), 64'd0);
        end

        $display("[TB] reset mid-stream");
        for (int i = 0; i < 9; i++) begin
            sb.push_back('{laneValue(6, 0, i), (i == 8)});
        end
        start = 1'b1;
        len   = LEN_W'(9);
        @(posedge clk); #1;
        start       = 1'b0;
        state_valid = 1'b1;
        state_in    = makeState(6, 0);
        @(posedge clk); #1;
        state_valid = 1'b0;
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        checkOutput("mid_rst_out", out, 64'd0);
        checkOutput("mid_rst_valid", 64'(out_valid), 64'd0);
        checkOutput("mid_rst_last", 64'(out_last), 64'd0);
        checkOutput("mid_rst_busy", 64'(busy), 64'd0);
        sb.delete();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        applyStimulus(1, 5, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
